// File: rtl/serial_receiver.sv
// serial_receiver: serial-to-parallel receiver for the lab byte link.
//
// Receives one line bit per sin_valid strobe and frames it as: start bit (0),
// WIDTH data bits LSB-first, an optional even-parity bit, and a stop bit (1).
// A good word lands in a holding register with a ready/ack handshake.
// Reception of the next frame continues while a word waits in the holding register.
//
// Optional feature macro: SERIAL_RECEIVER_PARITY_EN adds the parity bit and
// drives parity_err. Without it, parity_err is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears all state
//   sin        serial line bit (idles at 1)
//   sin_valid  sample sin on this clock edge
//   ack        consumer has taken Dout; clears ready
//   Dout       last good received word, stable while ready=1
//   ready      Dout holds an unconsumed word
//   frame_err  one-cycle pulse: stop bit sampled as 0
//   parity_err one-cycle pulse: parity mismatch
//   overrun    sticky: a good frame was dropped because ready was still set
module serial_receiver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             ack,
    output logic [WIDTH-1:0] Dout,
    output logic             ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StStop
`ifdef SERIAL_RECEIVER_PARITY_EN
        , StParity
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              par_q, par_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              complete;
`ifdef SERIAL_RECEIVER_PARITY_EN
    logic              bad_q, bad_d;
    logic              perr_q, perr_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        dout_d   = dout_q;
        ready_d  = ready_q;
        ovr_d    = ovr_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
        bad_d    = bad_q;
        perr_d   = 1'b0;
`endif

        if (sin_valid) begin
            case (state_q)
                StIdle: begin
                    if (!sin) begin
                        cnt_d   = '0;
                        par_d   = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
                        bad_d   = 1'b0;
`endif
                        state_d = StData;
                    end
                end
                StData: begin
                    // First data bit enters at the top and ends at bit 0.
                    shift_d = {sin, shift_q[WIDTH-1:1]};
                    par_d   = par_q ^ sin;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
`ifdef SERIAL_RECEIVER_PARITY_EN
                StParity: begin
                    bad_d   = par_q ^ sin;
                    state_d = StStop;
                end
`endif
                StStop: begin
                    state_d = StIdle;
                    if (!sin) begin
                        ferr_d = 1'b1;
`ifdef SERIAL_RECEIVER_PARITY_EN
                    end else if (bad_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        complete = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A completion wins over a coincident ack: the ack frees the slot the
        // new word drops into, so ready stays high.
        if (complete) begin
            if (!ready_q || ack) begin
                dout_d  = shift_q;
                ready_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (ack && ready_q) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
            bad_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef SERIAL_RECEIVER_PARITY_EN
            bad_q   <= bad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign Dout      = dout_q;
    assign ready     = ready_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef SERIAL_RECEIVER_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: frames are driven bit by bit, an
// abstract model of the holding register (word, ready, overrun) predicts the
// visible events, and a negedge monitor pops and checks them as they appear.
module tb_serial_receiver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         sin;
    logic         sin_valid;
    logic         ack;
    logic [W-1:0] Dout;
    logic         ready;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    serial_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .ack        (ack),
        .Dout       (Dout),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EvLoad, EvFerr, EvPerr, EvOvr, EvClr} ev_kind_e;
    typedef struct {
        ev_kind_e     kind;
        logic [W-1:0] data;
        int           due;
    } ev_t;
    ev_t exp_q[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Abstract model of the consumer-visible holding register.
    logic         m_ready = 1'b0;
    logic [W-1:0] m_dout  = '0;
    logic         m_ovr   = 1'b0;

    task automatic chk(string nm, int act, int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(ev_kind_e k, logic [W-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.due  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(logic b, logic a);
        sin       = b;
        sin_valid = 1'b1;
        ack       = a;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin       = 1'b1;
        ack       = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        if (m_ready) begin
            push(EvClr, m_dout);
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic send_frame(logic [W-1:0] data, logic stop_bit, logic par_bad,
                              int max_gap, logic ack_stop);
        logic pbit;
        logic good;
        pbit = (^data) ^ par_bad;
        strobe(1'b0, 1'b0);
        idle($urandom_range(0, max_gap));
        for (int i = 0; i < W; i++) begin
            strobe(data[i], 1'b0);
            idle($urandom_range(0, max_gap));
        end
`ifdef SERIAL_RECEIVER_PARITY_EN
        strobe(pbit, 1'b0);
        idle($urandom_range(0, max_gap));
`endif
        strobe(stop_bit, ack_stop);
        good = 1'b0;
        if (!stop_bit) begin
            push(EvFerr, m_dout);
`ifdef SERIAL_RECEIVER_PARITY_EN
        end else if (par_bad) begin
            push(EvPerr, m_dout);
`endif
        end else begin
            good = 1'b1;
            if (!m_ready || ack_stop) begin
                m_dout  = data;
                m_ready = 1'b1;
                push(EvLoad, data);
            end else begin
                if (!m_ovr) push(EvOvr, m_dout);
                m_ovr = 1'b1;
            end
        end
        if (ack_stop && !good && m_ready) begin
            push(EvClr, m_dout);
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // Monitor: every visible change of the outputs must match the next
    // queued expectation, in kind, cycle and data.
    bit           mon_en = 1'b0;
    logic         rdy_p  = 1'b0;
    logic         ovr_p  = 1'b0;
    logic [W-1:0] dout_p = '0;

    task automatic expect_ev(ev_kind_e k, string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL %s: unexpected event at cycle %0d, nothing queued", nm, cyc);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_kind"}, int'(k), int'(e.kind));
            chk({nm, "_cycle"}, cyc, e.due);
            chk({nm, "_Dout"}, int'(Dout), int'(e.data));
            if (k == EvClr) chk({nm, "_overrun"}, int'(overrun), 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_err) expect_ev(EvFerr, "frame_err");
            if (parity_err) expect_ev(EvPerr, "parity_err");
            if (ready && (!rdy_p || Dout != dout_p)) expect_ev(EvLoad, "load");
            if (!ready && rdy_p) expect_ev(EvClr, "ack_clear");
            if (overrun && !ovr_p) expect_ev(EvOvr, "overrun");
        end
        rdy_p  <= ready;
        ovr_p  <= overrun;
        dout_p <= Dout;
    end

    task automatic chk_all_zero(string nm);
        chk({nm, "_Dout"}, int'(Dout), 0);
        chk({nm, "_ready"}, int'(ready), 0);
        chk({nm, "_frame_err"}, int'(frame_err), 0);
        chk({nm, "_parity_err"}, int'(parity_err), 0);
        chk({nm, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        reset     = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b0;
        ack       = 1'b0;
        #12;
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        #1 mon_en = 1'b1;
        idle(1);

        // Gapless 0xA5, then consume it.
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        idle(1);
        do_ack();
        idle(2);

        // Same result with random idle gaps between strobes.
        send_frame(8'h3C, 1'b1, 1'b0, 5, 1'b0);
        idle(3);
        do_ack();

        // Bad stop bit, then an immediately following good frame.
        send_frame(8'h81, 1'b0, 1'b0, 0, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, 0, 1'b0);
        do_ack();

        // Overrun, then ack clears ready and overrun together.
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
        idle(2);
        do_ack();

        // Ack coinciding with the completion lets the new word in.
        send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 0, 1'b1);
        idle(1);
        do_ack();

        // Asynchronous reset part way through a frame, with a word held.
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
        idle(1);
        mon_en = 1'b0;
        strobe(1'b0, 1'b0);
        repeat (4) strobe(1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        chk("reset_queue_empty", exp_q.size(), 0);
        #1 reset = 1'b0;
        exp_q.delete();
        m_ready = 1'b0;
        m_dout  = '0;
        m_ovr   = 1'b0;
        @(negedge clk);
        #1 mon_en = 1'b1;
        idle(1);
        send_frame(8'h0F, 1'b1, 1'b0, 0, 1'b0);
        do_ack();

`ifdef SERIAL_RECEIVER_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0);
        do_ack();
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
`endif

        // Randomized traffic: random data, occasional bad stop or parity,
        // random gaps and acks.
        for (int n = 0; n < 40; n++) begin
            d = W'($urandom);
            send_frame(d, ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
                       $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 4));
            if ($urandom_range(0, 2) != 0) do_ack();
        end

        idle(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
